// File: rtl/sc_point_register_bank_pkg.sv
// Shared definitions for the point FSM, the register bank and the display blocks.
package sc_point_register_bank_pkg;

    localparam int SC_ROWS_DEF      = 8;
    localparam int SC_COLS_DEF      = 8;
    localparam int SC_START_COL_DEF = 3;
    localparam int SC_MOVE_W_DEF    = 8;

    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_HOLD  = 2'b11;

endpackage

// File: rtl/sc_point_row_register.sv
// One COLS-bit row of the frog bank: clear, parallel load, saturating left/right shift.
module sc_point_row_register
    import sc_point_register_bank_pkg::*;
#(
    parameter int               COLS    = SC_COLS_DEF,
    parameter logic [COLS-1:0]  RST_VAL = '0
) (
    input  logic            SC_STATEMACHINEPOINT_CLOCK_50,
    input  logic            SC_STATEMACHINEPOINT_RESET_InHigh,
    input  logic            clear_i,
    input  logic            load_i,
    input  logic [COLS-1:0] load_val_i,
    input  logic            shl_i,
    input  logic            shr_i,
    output logic [COLS-1:0] row_o,
    output logic            changed_o
);

    logic [COLS-1:0] row_q, row_d;

    // Edge bits block the shift so the frog never falls off the row.
    always_comb begin
        row_d = row_q;
        if (clear_i)
            row_d = RST_VAL;
        else if (load_i)
            row_d = load_val_i;
        else if (shl_i && !row_q[COLS-1])
            row_d = row_q << 1;
        else if (shr_i && !row_q[0])
            row_d = row_q >> 1;
    end

    always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
        if (SC_STATEMACHINEPOINT_RESET_InHigh)
            row_q <= RST_VAL;
        else
            row_q <= row_d;
    end

    assign row_o     = row_q;
    assign changed_o = (row_d != row_q);

endmodule

// File: rtl/sc_point_register_bank.sv
// Frog-position bank: command priority decode, row array, move counter and row flags.
module sc_point_register_bank
    import sc_point_register_bank_pkg::*;
#(
    parameter int ROWS      = SC_ROWS_DEF,
    parameter int COLS      = SC_COLS_DEF,
    parameter int START_COL = SC_START_COL_DEF,
    parameter int MOVE_W    = SC_MOVE_W_DEF
) (
    input  logic                 SC_STATEMACHINEPOINT_CLOCK_50,
    input  logic                 SC_STATEMACHINEPOINT_RESET_InHigh,
    input  logic                 SC_POINTBANK_clear_InLow,
    input  logic                 SC_POINTBANK_load0_InLow,
    input  logic                 SC_POINTBANK_load1_InLow,
    input  logic [1:0]           SC_POINTBANK_shiftselection_In,
    output logic [ROWS*COLS-1:0] SC_POINTBANK_Bank_Out,
    output logic                 SC_POINTBANK_FirstRegister_OutLow,
    output logic                 SC_POINTBANK_TopReached_OutHigh,
    output logic [MOVE_W-1:0]    SC_POINTBANK_Moves_Out
);

    localparam logic [COLS-1:0] START_ROW = {{(COLS-1){1'b0}}, 1'b1} << START_COL;

    logic [ROWS-1:0][COLS-1:0] row;
    logic [ROWS-1:0][COLS-1:0] load_val;
    logic [ROWS-1:0]           changed;
    logic                      clr, up, dn, shl, shr, up_en, dn_en, eff;
    logic [MOVE_W-1:0]         moves_q, moves_d;

    assign clr   = ~SC_POINTBANK_clear_InLow;
    assign up    = ~clr & ~SC_POINTBANK_load0_InLow;
    assign dn    = ~clr & SC_POINTBANK_load0_InLow & ~SC_POINTBANK_load1_InLow;
    assign shl   = ~clr & SC_POINTBANK_load0_InLow & SC_POINTBANK_load1_InLow &
                   (SC_POINTBANK_shiftselection_In == SHIFT_LEFT);
    assign shr   = ~clr & SC_POINTBANK_load0_InLow & SC_POINTBANK_load1_InLow &
                   (SC_POINTBANK_shiftselection_In == SHIFT_RIGHT);
    // Vertical moves are suppressed at the boundary rows instead of wrapping.
    assign up_en = up & ~(|row[ROWS-1]);
    assign dn_en = dn & ~(|row[0]);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [COLS-1:0] below, above;
        if (r == 0) begin : g_bot
            assign below = '0;
        end else begin : g_nbot
            assign below = row[r-1];
        end
        if (r == ROWS-1) begin : g_top
            assign above = '0;
        end else begin : g_ntop
            assign above = row[r+1];
        end
        assign load_val[r] = up_en ? below : above;

        sc_point_row_register #(
            .COLS    (COLS),
            .RST_VAL ((r == 0) ? START_ROW : '0)
        ) u_row (
            .SC_STATEMACHINEPOINT_CLOCK_50     (SC_STATEMACHINEPOINT_CLOCK_50),
            .SC_STATEMACHINEPOINT_RESET_InHigh (SC_STATEMACHINEPOINT_RESET_InHigh),
            .clear_i    (clr),
            .load_i     (up_en | dn_en),
            .load_val_i (load_val[r]),
            .shl_i      (shl),
            .shr_i      (shr),
            .row_o      (row[r]),
            .changed_o  (changed[r])
        );
    end

    assign eff = ~clr & (|changed);

    always_comb begin
        moves_d = moves_q;
        if (clr)
            moves_d = '0;
        else if (eff && (moves_q != {MOVE_W{1'b1}}))
            moves_d = moves_q + 1'b1;
    end

    always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
        if (SC_STATEMACHINEPOINT_RESET_InHigh)
            moves_q <= '0;
        else
            moves_q <= moves_d;
    end

    assign SC_POINTBANK_Bank_Out             = row;
    assign SC_POINTBANK_FirstRegister_OutLow = ~(|row[0]);
    assign SC_POINTBANK_TopReached_OutHigh   = |row[ROWS-1];
    assign SC_POINTBANK_Moves_Out            = moves_q;

endmodule

// File: tb/tb_sc_point_register_bank.sv
// Directed bench for sc_point_register_bank with hand-computed expectations.
module tb_sc_point_register_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_n = 1'b1, load0_n = 1'b1, load1_n = 1'b1;
    logic [1:0]  sel = 2'b11;
    logic [63:0] bank;
    logic        first_n, top;
    logic [7:0]  moves;
    int          checks = 0;
    int          errors = 0;

    sc_point_register_bank #(.ROWS(8), .COLS(8), .START_COL(3), .MOVE_W(8)) dut (
        .SC_STATEMACHINEPOINT_CLOCK_50     (clk),
        .SC_STATEMACHINEPOINT_RESET_InHigh (rst),
        .SC_POINTBANK_clear_InLow          (clear_n),
        .SC_POINTBANK_load0_InLow          (load0_n),
        .SC_POINTBANK_load1_InLow          (load1_n),
        .SC_POINTBANK_shiftselection_In    (sel),
        .SC_POINTBANK_Bank_Out             (bank),
        .SC_POINTBANK_FirstRegister_OutLow (first_n),
        .SC_POINTBANK_TopReached_OutHigh   (top),
        .SC_POINTBANK_Moves_Out            (moves)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic c_n, input logic l0, input logic l1, input logic [1:0] s);
        @(negedge clk);
        clear_n = c_n; load0_n = l0; load1_n = l1; sel = s;
        @(posedge clk);
        #1;
        clear_n = 1'b1; load0_n = 1'b1; load1_n = 1'b1; sel = 2'b11;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_bank",  bank, 64'h08);
        chk("rst_first", first_n, 1'b0);
        chk("rst_top",   top, 1'b0);
        chk("rst_moves", moves, 8'd0);
        rst = 1'b0;

        step(1, 0, 1, 2'b11);
        chk("up_bank",  bank, 64'h0800);
        chk("up_first", first_n, 1'b1);
        chk("up_moves", moves, 8'd1);

        step(0, 1, 1, 2'b11);
        chk("clr_bank",  bank, 64'h08);
        chk("clr_moves", moves, 8'd0);
        repeat (4) step(1, 1, 1, 2'b01);
        chk("shl4_bank",  bank, 64'h80);
        chk("shl4_moves", moves, 8'd4);
        step(1, 1, 1, 2'b01);
        chk("shl_sat_bank",  bank, 64'h80);
        chk("shl_sat_moves", moves, 8'd4);

        step(0, 1, 1, 2'b11);
        repeat (7) step(1, 0, 1, 2'b11);
        chk("top_bank",  bank, 64'h0800_0000_0000_0000);
        chk("top_flag",  top, 1'b1);
        chk("top_moves", moves, 8'd7);
        step(1, 0, 1, 2'b11);
        chk("top_blk_bank",  bank, 64'h0800_0000_0000_0000);
        chk("top_blk_moves", moves, 8'd7);

        repeat (3) step(1, 1, 1, 2'b10);
        chk("shr3_bank",  bank, 64'h0100_0000_0000_0000);
        chk("shr3_moves", moves, 8'd10);
        step(1, 1, 1, 2'b10);
        chk("shr_sat_bank",  bank, 64'h0100_0000_0000_0000);
        chk("shr_sat_moves", moves, 8'd10);
        step(1, 1, 1, 2'b00);
        chk("illegal_bank", bank, 64'h0100_0000_0000_0000);
        step(1, 1, 0, 2'b11);
        chk("dn_bank",  bank, 64'h0001_0000_0000_0000);
        chk("dn_top",   top, 1'b0);
        chk("dn_moves", moves, 8'd11);

        step(0, 0, 1, 2'b11);
        chk("clr_pri_bank",  bank, 64'h08);
        chk("clr_pri_moves", moves, 8'd0);
        step(1, 1, 0, 2'b11);
        chk("dn_blk_bank",  bank, 64'h08);
        chk("dn_blk_first", first_n, 1'b0);
        chk("dn_blk_moves", moves, 8'd0);

        step(1, 0, 0, 2'b01);
        chk("l0_pri_bank",  bank, 64'h0800);
        chk("l0_pri_moves", moves, 8'd1);
        step(1, 1, 0, 2'b01);
        chk("l1_pri_bank",  bank, 64'h08);
        chk("l1_pri_moves", moves, 8'd2);

        for (int i = 0; i < 130; i++) begin
            step(1, 1, 1, 2'b01);
            step(1, 1, 1, 2'b10);
        end
        chk("sat_moves", moves, 8'd255);
        chk("sat_bank",  bank, 64'h08);

        step(1, 0, 1, 2'b11);
        chk("pre_rst_bank", bank, 64'h0800);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_bank",  bank, 64'h08);
        chk("async_rst_moves", moves, 8'd0);
        chk("async_rst_first", first_n, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
